// File: rtl/tsp16_mem_pkg.sv
// Shared types and defaults for the TSP16 memory data-port arbiter.
//   owner_e     : which requester owns the outstanding Memory transaction
//   arb_state_e : arbiter FSM states
//   MEM_ADDR_W / MEM_DATA_W : default address/data widths of the data port
package tsp16_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_DATA
  } owner_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester handshakes and the Memory data port around the arbiter.
//   fetch_* : instruction-read requester (req/addr in, gnt/valid/rdata out)
//   data_*  : load/store requester (req/write/addr/wdata in, gnt/valid/rdata out)
//   mem_*   : issue strobe, write flag, address, write data out; read data in
// Modports: slave = arbiter view, master = environment (requesters + Memory) view.
interface mem_port_arbiter_if
  import tsp16_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_rdata;

  logic              data_req;
  logic              data_write;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_gnt;
  logic              data_valid;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_en;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_gnt, fetch_valid, fetch_rdata,
    input  data_req, data_write, data_addr, data_wdata,
    output data_gnt, data_valid, data_rdata,
    output mem_en, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_gnt, fetch_valid, fetch_rdata,
    output data_req, data_write, data_addr, data_wdata,
    input  data_gnt, data_valid, data_rdata,
    input  mem_en, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_streak_counter.sv
// Fairness counter for the data-port arbiter: counts consecutive data grants
// made while fetch is waiting, saturating at MAX_DATA_STREAK.
//   clk, reset  : clock, synchronous active-high reset
//   data_gnt    : a data transaction was issued this cycle
//   fetch_gnt   : a fetch transaction was issued this cycle
//   fetch_req   : fetch is requesting this cycle
//   force_fetch : streak has reached MAX_DATA_STREAK, fetch must win next issue
module mem_arb_streak_counter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic data_gnt,
  input  logic fetch_gnt,
  input  logic fetch_req,
  output logic force_fetch
);

  localparam logic [3:0] StreakMax = 4'(MAX_DATA_STREAK);

  logic [3:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    // Fetch being served, or not waiting at all, ends any streak.
    if (fetch_gnt || !fetch_req) begin
      streak_d = '0;
    end else if (data_gnt && (streak_q != StreakMax)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign force_fetch = (streak_q == StreakMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported Memory data port between the fetch stage (instruction
// reads) and the memory stage (loads/stores). One transaction is outstanding at a
// time; its response is routed back to the owner MEM_LATENCY cycles after issue.
//   clk, reset : clock, synchronous active-high reset
//   bus        : requester handshakes and Memory port (widths set by the interface)
// Parameters:
//   MEM_LATENCY     : issue-to-read-data cycles, 1..7
//   MAX_DATA_STREAK : data grants allowed in a row while fetch waits, 1..15
// Grants and mem_* are combinational from the requests so a transaction can be
// issued in the same cycle the previous one completes.
module mem_port_arbiter
  import tsp16_mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY     = 1,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [2:0] CntLoad = 3'(MEM_LATENCY - 1);

  arb_state_e state_q;
  owner_e     owner_q;
  logic       write_q;
  logic [2:0] cnt_q;

  logic completing;
  logic issue_ok;
  logic force_fetch;
  logic pick_fetch;
  logic pick_data;

  // The outstanding transaction finishes when the down-counter has run out.
  assign completing = !reset && (state_q == ARB_BUSY) && (cnt_q == 3'd0);
  assign issue_ok   = !reset && ((state_q == ARB_IDLE) || completing);

  // Data has priority unless fetch has been passed over too many times.
  assign pick_fetch = issue_ok && bus.fetch_req && (force_fetch || !bus.data_req);
  assign pick_data  = issue_ok && bus.data_req && !pick_fetch;

  mem_arb_streak_counter #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_streak (
    .clk        (clk),
    .reset      (reset),
    .data_gnt   (pick_data),
    .fetch_gnt  (pick_fetch),
    .fetch_req  (bus.fetch_req),
    .force_fetch(force_fetch)
  );

  assign bus.fetch_gnt = pick_fetch;
  assign bus.data_gnt  = pick_data;
  assign bus.mem_en    = pick_fetch | pick_data;
  assign bus.mem_write = pick_data & bus.data_write;
  assign bus.mem_addr  = pick_data  ? bus.data_addr  :
                         pick_fetch ? bus.fetch_addr : '0;
  assign bus.mem_wdata = pick_data ? bus.data_wdata : '0;

  assign bus.fetch_valid = completing && (owner_q == OWN_FETCH);
  assign bus.data_valid  = completing && (owner_q == OWN_DATA);
  assign bus.fetch_rdata = bus.fetch_valid ? bus.mem_rdata : '0;
  assign bus.data_rdata  = (bus.data_valid && !write_q) ? bus.mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
      write_q <= 1'b0;
      cnt_q   <= 3'd0;
    end else if (pick_fetch || pick_data) begin
      state_q <= ARB_BUSY;
      owner_q <= pick_fetch ? OWN_FETCH : OWN_DATA;
      write_q <= pick_data & bus.data_write;
      cnt_q   <= CntLoad;
    end else if (completing) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
      write_q <= 1'b0;
    end else if (state_q == ARB_BUSY) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  a_one_gnt : assert property (@(posedge clk) disable iff (reset)
    !(bus.fetch_gnt && bus.data_gnt));
  a_en_gnt : assert property (@(posedge clk) disable iff (reset)
    bus.mem_en == (bus.fetch_gnt || bus.data_gnt));
  a_one_valid : assert property (@(posedge clk) disable iff (reset)
    !(bus.fetch_valid && bus.data_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 and latency 3, streak limit 4)
// checked every cycle against a transaction-level model, plus directed scenarios.
module tb_mem_port_arbiter;
  import tsp16_mem_pkg::*;

  localparam int unsigned MaxStreak = 4;

  typedef struct packed {
    logic        freq;
    logic [15:0] faddr;
    logic        dreq;
    logic        dwr;
    logic [15:0] daddr;
    logic [15:0] dwdata;
    logic [15:0] mrdata;
  } in_t;

  typedef struct packed {
    logic        fgnt;
    logic        fvalid;
    logic [15:0] frdata;
    logic        dgnt;
    logic        dvalid;
    logic [15:0] drdata;
    logic        men;
    logic        mwr;
    logic [15:0] maddr;
    logic [15:0] mwdata;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [2] = '{1'b1, 1'b1};
  in_t  drv [2] = '{default: '0};
  out_t got [2];

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus3 ();

  mem_port_arbiter #(.MEM_LATENCY(1), .MAX_DATA_STREAK(MaxStreak)) dut1 (
    .clk  (clk),
    .reset(rst[0]),
    .bus  (bus1.slave)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .MAX_DATA_STREAK(MaxStreak)) dut3 (
    .clk  (clk),
    .reset(rst[1]),
    .bus  (bus3.slave)
  );

  assign bus1.fetch_req  = drv[0].freq;
  assign bus1.fetch_addr = drv[0].faddr;
  assign bus1.data_req   = drv[0].dreq;
  assign bus1.data_write = drv[0].dwr;
  assign bus1.data_addr  = drv[0].daddr;
  assign bus1.data_wdata = drv[0].dwdata;
  assign bus1.mem_rdata  = drv[0].mrdata;
  assign bus3.fetch_req  = drv[1].freq;
  assign bus3.fetch_addr = drv[1].faddr;
  assign bus3.data_req   = drv[1].dreq;
  assign bus3.data_write = drv[1].dwr;
  assign bus3.data_addr  = drv[1].daddr;
  assign bus3.data_wdata = drv[1].dwdata;
  assign bus3.mem_rdata  = drv[1].mrdata;

  assign got[0] = '{fgnt: bus1.fetch_gnt, fvalid: bus1.fetch_valid, frdata: bus1.fetch_rdata,
                    dgnt: bus1.data_gnt, dvalid: bus1.data_valid, drdata: bus1.data_rdata,
                    men: bus1.mem_en, mwr: bus1.mem_write, maddr: bus1.mem_addr,
                    mwdata: bus1.mem_wdata};
  assign got[1] = '{fgnt: bus3.fetch_gnt, fvalid: bus3.fetch_valid, frdata: bus3.fetch_rdata,
                    dgnt: bus3.data_gnt, dvalid: bus3.data_valid, drdata: bus3.data_rdata,
                    men: bus3.mem_en, mwr: bus3.mem_write, maddr: bus3.mem_addr,
                    mwdata: bus3.mem_wdata};

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string name, int lane, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane%0d @%0t: got %h, expected %h", name, lane, $time, act, exp);
    end
  endfunction

  // Transaction-level model: one outstanding transaction with an absolute finish cycle.
  int unsigned cyc = 0;
  bit          has_txn [2] = '{0, 0};
  int unsigned done_at [2] = '{0, 0};
  owner_e      own     [2] = '{OWN_NONE, OWN_NONE};
  bit          own_wr  [2] = '{0, 0};
  int unsigned streak  [2] = '{0, 0};

  function automatic int unsigned lat(int l);
    return (l == 0) ? 1 : 3;
  endfunction

  function automatic void model_check(int l);
    in_t  i = drv[l];
    out_t a = got[l];
    bit complete, free, fw, dw;
    if (rst[l]) begin
      has_txn[l] = 0;
      streak[l]  = 0;
      chk("reset_quiet", l, {10'd0, a.fgnt, a.dgnt, a.fvalid, a.dvalid, a.men, a.mwr}, 16'd0);
      return;
    end
    complete = has_txn[l] && (cyc == done_at[l]);
    free     = !has_txn[l] || complete;
    fw       = free && i.freq && (!i.dreq || streak[l] == MaxStreak);
    dw       = free && i.dreq && !fw;
    chk("fetch_gnt", l, a.fgnt, fw);
    chk("data_gnt", l, a.dgnt, dw);
    chk("mem_en", l, a.men, fw | dw);
    chk("mem_write", l, a.mwr, dw & i.dwr);
    if (fw) chk("mem_addr", l, a.maddr, i.faddr);
    if (dw) chk("mem_addr", l, a.maddr, i.daddr);
    if (dw && i.dwr) chk("mem_wdata", l, a.mwdata, i.dwdata);
    chk("fetch_valid", l, a.fvalid, complete && own[l] == OWN_FETCH);
    chk("data_valid", l, a.dvalid, complete && own[l] == OWN_DATA);
    if (complete && own[l] == OWN_FETCH) chk("fetch_rdata", l, a.frdata, i.mrdata);
    if (complete && own[l] == OWN_DATA && !own_wr[l]) chk("data_rdata", l, a.drdata, i.mrdata);
    if (!i.freq || fw) streak[l] = 0;
    else if (dw && streak[l] < MaxStreak) streak[l]++;
    if (fw || dw) begin
      has_txn[l] = 1;
      done_at[l] = cyc + lat(l);
      own[l]     = fw ? OWN_FETCH : OWN_DATA;
      own_wr[l]  = dw && i.dwr;
    end else if (complete) begin
      has_txn[l] = 0;
    end
  endfunction

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) model_check(l);
    cyc++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  logic [9:0] fpat, dpat, gpat, vpat;
  bit         fg [2];

  initial begin
    next_cycle();
    next_cycle();
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Fetch-only read, latency 1.
    drv[0].freq = 1'b1; drv[0].faddr = 16'h0010;
    sample();
    chk("d_fetch_gnt", 0, got[0].fgnt, 1'b1);
    chk("d_fetch_men", 0, got[0].men, 1'b1);
    chk("d_fetch_addr", 0, got[0].maddr, 16'h0010);
    next_cycle();
    drv[0].freq = 1'b0; drv[0].mrdata = 16'hABCD;
    sample();
    chk("d_fetch_valid", 0, got[0].fvalid, 1'b1);
    chk("d_fetch_rdata", 0, got[0].frdata, 16'hABCD);

    // Contention: data load wins, fetch follows at completion.
    next_cycle();
    drv[0].freq = 1'b1; drv[0].faddr = 16'h0050;
    drv[0].dreq = 1'b1; drv[0].dwr = 1'b0; drv[0].daddr = 16'h0040;
    sample();
    chk("d_cont_dgnt", 0, got[0].dgnt, 1'b1);
    chk("d_cont_fgnt0", 0, got[0].fgnt, 1'b0);
    chk("d_cont_addr", 0, got[0].maddr, 16'h0040);
    next_cycle();
    drv[0].dreq = 1'b0; drv[0].mrdata = 16'h5A5A;
    sample();
    chk("d_cont_dvalid", 0, got[0].dvalid, 1'b1);
    chk("d_cont_drdata", 0, got[0].drdata, 16'h5A5A);
    chk("d_cont_fgnt1", 0, got[0].fgnt, 1'b1);
    next_cycle();
    drv[0].freq = 1'b0; drv[0].mrdata = 16'h0F0F;
    sample();
    chk("d_cont_fvalid", 0, got[0].fvalid, 1'b1);
    chk("d_cont_frdata", 0, got[0].frdata, 16'h0F0F);

    // Store: one-cycle issue, data_valid one cycle later.
    next_cycle();
    drv[0].dreq = 1'b1; drv[0].dwr = 1'b1; drv[0].daddr = 16'h0020; drv[0].dwdata = 16'h1234;
    sample();
    chk("d_st_men", 0, got[0].men, 1'b1);
    chk("d_st_mwr", 0, got[0].mwr, 1'b1);
    chk("d_st_addr", 0, got[0].maddr, 16'h0020);
    chk("d_st_wdata", 0, got[0].mwdata, 16'h1234);
    next_cycle();
    drv[0].dreq = 1'b0; drv[0].dwr = 1'b0;
    sample();
    chk("d_st_men_off", 0, got[0].men, 1'b0);
    chk("d_st_dvalid", 0, got[0].dvalid, 1'b1);
    chk("d_st_fvalid0", 0, got[0].fvalid, 1'b0);

    // Starvation: both held -> D,D,D,D,F,D,D,D,D,F.
    next_cycle();
    drv[0].freq = 1'b1; drv[0].faddr = 16'h0100;
    drv[0].dreq = 1'b1; drv[0].daddr = 16'h0200;
    for (int k = 0; k < 10; k++) begin
      sample();
      fpat[k] = got[0].fgnt;
      dpat[k] = got[0].dgnt;
      next_cycle();
    end
    chk("d_starve_f", 0, {6'd0, fpat}, {6'd0, 10'b1000010000});
    chk("d_starve_d", 0, {6'd0, dpat}, {6'd0, 10'b0111101111});
    drv[0].freq = 1'b0; drv[0].dreq = 1'b0;

    // Back-to-back fetches, latency 3.
    drv[1].freq = 1'b1; drv[1].faddr = 16'h0300;
    for (int k = 0; k < 10; k++) begin
      sample();
      gpat[k] = got[1].fgnt;
      vpat[k] = got[1].fvalid;
      next_cycle();
      if (k == 6) drv[1].freq = 1'b0;
    end
    chk("d_b2b_gnt", 1, {6'd0, gpat}, {6'd0, 10'b0001001001});
    chk("d_b2b_valid", 1, {6'd0, vpat}, {6'd0, 10'b1001001000});

    // Reset in the cycle after issue drops the transaction.
    drv[1].freq = 1'b1; drv[1].faddr = 16'h0400;
    sample();
    chk("d_rst_issue", 1, got[1].fgnt, 1'b1);
    next_cycle();
    rst[1] = 1'b1; drv[1].freq = 1'b0;
    sample();
    next_cycle();
    rst[1] = 1'b0;
    sample();
    chk("d_rst_quiet", 1, {10'd0, got[1].fgnt, got[1].dgnt, got[1].fvalid, got[1].dvalid,
                           got[1].men, got[1].mwr}, 16'd0);
    next_cycle();
    drv[1].freq = 1'b1; drv[1].faddr = 16'h0500;
    sample();
    chk("d_rst_novalid", 1, got[1].fvalid, 1'b0);
    chk("d_rst_regnt", 1, got[1].fgnt, 1'b1);
    chk("d_rst_readdr", 1, got[1].maddr, 16'h0500);
    next_cycle();
    drv[1].freq = 1'b0;

    // Random traffic; requests are held until granted.
    for (int c = 0; c < 4000; c++) begin
      sample();
      fg[0] = got[0].fgnt;
      fg[1] = got[1].fgnt;
      dpat[0] = got[0].dgnt;
      dpat[1] = got[1].dgnt;
      next_cycle();
      for (int l = 0; l < 2; l++) begin
        if (!drv[l].freq || fg[l]) begin
          drv[l].freq  = ($urandom_range(0, 3) != 0);
          drv[l].faddr = 16'($urandom);
        end
        if (!drv[l].dreq || dpat[l]) begin
          drv[l].dreq   = ($urandom_range(0, 2) != 0);
          drv[l].dwr    = 1'($urandom);
          drv[l].daddr  = 16'($urandom);
          drv[l].dwdata = 16'($urandom);
        end
        drv[l].mrdata = 16'($urandom);
        rst[l] = ($urandom_range(0, 299) == 0);
      end
    end
    sample();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
